// File: rtl/inst_fetch_queue_if.sv
// Bundle interface between the fetch stages (master) and the instruction queue (slave).
// Each lane k of a packed bus sits at [k*width +: width].
interface inst_fetch_queue_if #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32
);
  localparam int CW = $clog2(ISSUE_W + 1);
  localparam int OW = $clog2(DEPTH + 1);

  logic                      flush;
  logic                      flush_keep;
  logic [CW-1:0]             enq_cnt;
  logic [ISSUE_W*DATA_W-1:0] enq_inst;
  logic [ISSUE_W*32-1:0]     enq_pc;
  logic [ISSUE_W*2-1:0]      enq_exc;
  logic                      enq_ready;
  logic [CW-1:0]             deq_avail;
  logic [ISSUE_W*DATA_W-1:0] deq_inst;
  logic [ISSUE_W*32-1:0]     deq_pc;
  logic [ISSUE_W*2-1:0]      deq_exc;
  logic [CW-1:0]             deq_cnt;
  logic [OW-1:0]             occupancy;
  logic                      overflow_err;

  modport master (
    output flush, flush_keep, enq_cnt, enq_inst, enq_pc, enq_exc, deq_cnt,
    input  enq_ready, deq_avail, deq_inst, deq_pc, deq_exc, occupancy, overflow_err
  );

  modport slave (
    input  flush, flush_keep, enq_cnt, enq_inst, enq_pc, enq_exc, deq_cnt,
    output enq_ready, deq_avail, deq_inst, deq_pc, deq_exc, occupancy, overflow_err
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Multi-lane in-order instruction queue between fetch and decode, with full flush
// and a delay-slot-preserving flush that keeps the oldest surviving entry.
module inst_fetch_queue #(
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.slave  bus
);
  localparam int CW = $clog2(ISSUE_W + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [31:0]       mem_pc   [DEPTH];
  logic [1:0]        mem_exc  [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [OW-1:0] count;
  logic          overflow;

  logic          ready;
  logic [CW-1:0] avail;
  logic [CW-1:0] enq_clamp;
  logic [CW-1:0] enq_eff;
  logic [CW-1:0] deq_eff;
  logic [AW-1:0] head_adv;
  logic [OW-1:0] remain;

  // Readiness looks only at registered count so fetch never sees a path from deq_cnt.
  assign ready     = count <= OW'(DEPTH - ISSUE_W);
  assign avail     = (count < OW'(ISSUE_W)) ? CW'(count) : CW'(ISSUE_W);
  assign enq_clamp = (bus.enq_cnt > CW'(ISSUE_W)) ? CW'(ISSUE_W) : bus.enq_cnt;
  assign enq_eff   = (ready && !bus.flush) ? enq_clamp : '0;
  assign deq_eff   = (bus.deq_cnt < avail) ? bus.deq_cnt : avail;
  assign head_adv  = head + AW'(deq_eff);
  assign remain    = count - OW'(deq_eff);

  always_ff @(posedge clk) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // A bundle arriving during a flush is discarded on purpose, not dropped.
      if (bus.enq_cnt != '0 && !ready && !bus.flush)
        overflow <= 1'b1;
      if (bus.flush) begin
        if (bus.flush_keep && remain != '0) begin
          head  <= head_adv;
          tail  <= head_adv + AW'(1);
          count <= OW'(1);
        end else begin
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end
      end else begin
        head  <= head_adv;
        tail  <= tail + AW'(enq_eff);
        count <= remain + OW'(enq_eff);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (k < int'(enq_eff)) begin
          mem_inst[tail + AW'(k)] <= bus.enq_inst[k*DATA_W +: DATA_W];
          mem_pc[tail + AW'(k)]   <= bus.enq_pc[k*32 +: 32];
          mem_exc[tail + AW'(k)]  <= bus.enq_exc[k*2 +: 2];
        end
      end
    end
  end

  // Lanes beyond the available count read as zero so decode sees clean bubbles.
  always_comb begin
    bus.deq_inst = '0;
    bus.deq_pc   = '0;
    bus.deq_exc  = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (k < int'(avail)) begin
        bus.deq_inst[k*DATA_W +: DATA_W] = mem_inst[head + AW'(k)];
        bus.deq_pc[k*32 +: 32]           = mem_pc[head + AW'(k)];
        bus.deq_exc[k*2 +: 2]            = mem_exc[head + AW'(k)];
      end
    end
  end

  assign bus.enq_ready    = ready;
  assign bus.deq_avail    = avail;
  assign bus.occupancy    = count;
  assign bus.overflow_err = overflow;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 8;
  localparam int DATA_W  = 32;

  typedef struct {
    logic [DATA_W-1:0] inst;
    logic [31:0]       pc;
    logic [1:0]        exc;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ent_t q[$];
  bit   m_ovf;

  inst_fetch_queue_if #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  inst_fetch_queue #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [ISSUE_W*DATA_W-1:0] exp_inst();
    logic [ISSUE_W*DATA_W-1:0] v = '0;
    for (int k = 0; k < ISSUE_W; k++)
      if (k < q.size()) v[k*DATA_W +: DATA_W] = q[k].inst;
    return v;
  endfunction

  function automatic logic [ISSUE_W*32-1:0] exp_pc();
    logic [ISSUE_W*32-1:0] v = '0;
    for (int k = 0; k < ISSUE_W; k++)
      if (k < q.size()) v[k*32 +: 32] = q[k].pc;
    return v;
  endfunction

  function automatic logic [ISSUE_W*2-1:0] exp_exc();
    logic [ISSUE_W*2-1:0] v = '0;
    for (int k = 0; k < ISSUE_W; k++)
      if (k < q.size()) v[k*2 +: 2] = q[k].exc;
    return v;
  endfunction

  task automatic drive(bit f, bit fk, int ec, int dc);
    bus.flush      = f;
    bus.flush_keep = fk;
    bus.enq_cnt    = ec[1:0];
    bus.deq_cnt    = dc[1:0];
  endtask

  task automatic set_bundle(logic [31:0] pc0, logic [31:0] pc1);
    bus.enq_pc   = {pc1, pc0};
    bus.enq_inst = {$urandom(), $urandom()};
    bus.enq_exc  = 4'($urandom_range(0, 15));
  endtask

  // One clock: the model applies the queue rules to the stimulus the bench drove.
  task automatic tick();
    int   avail, d, e;
    bit   ready;
    ent_t h;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_ovf = 0;
    end else begin
      avail = imin(q.size(), ISSUE_W);
      d     = imin(int'(bus.deq_cnt), avail);
      ready = (DEPTH - q.size()) >= ISSUE_W;
      e     = ready ? imin(int'(bus.enq_cnt), ISSUE_W) : 0;
      if (!ready && bus.enq_cnt != 0 && !bus.flush) m_ovf = 1;
      repeat (d) void'(q.pop_front());
      if (bus.flush) begin
        if (bus.flush_keep && q.size() > 0) begin
          h = q[0];
          q.delete();
          q.push_back(h);
        end else begin
          q.delete();
        end
      end else begin
        for (int k = 0; k < e; k++) begin
          h.inst = bus.enq_inst[k*DATA_W +: DATA_W];
          h.pc   = bus.enq_pc[k*32 +: 32];
          h.exc  = bus.enq_exc[k*2 +: 2];
          q.push_back(h);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 0, 2, 0);
    set_bundle(32'h100, 32'h104);
    tick();
    tick();
    drive(0, 0, 0, 0);
    reset = 1'b1;
    checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", bus.occupancy); end
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.enq_ready); end
    checks++; if (bus.deq_avail !== 2'd0) begin errors++; $display("FAIL reset_avail got %0d exp 0", bus.deq_avail); end
    checks++; if (bus.deq_pc !== '0 || bus.deq_inst !== '0 || bus.deq_exc !== '0) begin
      errors++; $display("FAIL reset_deq got pc %0h inst %0h exc %0h exp 0", bus.deq_pc, bus.deq_inst, bus.deq_exc);
    end
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", bus.overflow_err); end
  endtask

  task automatic test_fill();
    for (int b = 0; b < 4; b++) begin
      drive(0, 0, 2, 0);
      set_bundle(32'(8*b), 32'(8*b + 4));
      tick();
      if (b == 0) begin
        checks++; if (bus.deq_avail !== 2'd2) begin errors++; $display("FAIL fill_latency got %0d exp 2", bus.deq_avail); end
        checks++; if (bus.deq_pc !== {32'h4, 32'h0}) begin errors++; $display("FAIL fill_order got %0h exp 0000000400000000", bus.deq_pc); end
      end
    end
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd8) begin errors++; $display("FAIL fill_occ got %0d exp 8", bus.occupancy); end
    checks++; if (bus.enq_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b exp 0", bus.enq_ready); end
    checks++; if (bus.deq_inst !== exp_inst() || bus.deq_exc !== exp_exc()) begin
      errors++; $display("FAIL fill_data got %0h/%0h exp %0h/%0h", bus.deq_inst, bus.deq_exc, exp_inst(), exp_exc());
    end
  endtask

  task automatic test_overflow();
    drive(0, 0, 1, 0);
    set_bundle(32'hDEAD0, 32'hDEAD4);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd8) begin errors++; $display("FAIL ovf_occ got %0d exp 8", bus.occupancy); end
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", bus.overflow_err); end
  endtask

  task automatic test_wrap();
    int guard = 0;
    drive(0, 0, 0, 2);
    tick();
    checks++; if (bus.occupancy !== 4'd6 || bus.deq_pc[31:0] !== 32'h08) begin
      errors++; $display("FAIL wrap_first got occ %0d pc %0h exp occ 6 pc 8", bus.occupancy, bus.deq_pc[31:0]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2, 2);
      set_bundle(32'(32'h20 + 8*i), 32'(32'h24 + 8*i));
      tick();
      checks++; if (bus.occupancy !== 4'd6) begin errors++; $display("FAIL wrap_occ%0d got %0d exp 6", i, bus.occupancy); end
      checks++; if (bus.deq_pc !== {32'(32'h14 + 8*i), 32'(32'h10 + 8*i)}) begin
        errors++; $display("FAIL wrap_pc%0d got %0h exp %0h", i, bus.deq_pc, {32'(32'h14 + 8*i), 32'(32'h10 + 8*i)});
      end
    end
    // Drain: remaining pcs must come out in order 0x28..0x3C.
    while (bus.occupancy != 0 && guard < 20) begin
      checks++; if (bus.deq_pc !== exp_pc()) begin errors++; $display("FAIL drain_pc got %0h exp %0h", bus.deq_pc, exp_pc()); end
      drive(0, 0, 0, 2);
      tick();
      guard++;
    end
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd0 || guard != 3) begin errors++; $display("FAIL drain_done got occ %0d cycles %0d exp occ 0 cycles 3", bus.occupancy, guard); end
    checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", bus.overflow_err); end
  endtask

  task automatic test_keep_flush();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    reset = 1'b1;
    checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", bus.overflow_err); end
    drive(0, 0, 2, 0);
    set_bundle(32'h40, 32'h44);
    tick();
    drive(0, 0, 1, 0);
    set_bundle(32'h48, 32'h4C);
    tick();
    drive(1, 1, 2, 1);
    set_bundle(32'h50, 32'h54);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd1 || bus.deq_avail !== 2'd1) begin
      errors++; $display("FAIL keep_occ got occ %0d avail %0d exp 1 1", bus.occupancy, bus.deq_avail);
    end
    checks++; if (bus.deq_pc !== {32'h0, 32'h44}) begin errors++; $display("FAIL keep_pc got %0h exp 44", bus.deq_pc); end
    checks++; if (bus.deq_inst[2*DATA_W-1:DATA_W] !== '0 || bus.deq_exc[3:2] !== 2'b00 || bus.deq_inst !== exp_inst()) begin
      errors++; $display("FAIL keep_lanes got %0h exp %0h", bus.deq_inst, exp_inst());
    end
  endtask

  task automatic test_full_flush();
    drive(0, 0, 2, 0);
    set_bundle(32'h58, 32'h5C);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", bus.occupancy); end
    drive(1, 0, 2, 0);
    set_bundle(32'h80, 32'h84);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd0 || bus.overflow_err !== 1'b0) begin
      errors++; $display("FAIL flush_full got occ %0d ovf %0b exp 0 0", bus.occupancy, bus.overflow_err);
    end
    drive(0, 0, 1, 0);
    set_bundle(32'h60, 32'h64);
    tick();
    drive(0, 0, 0, 2);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.occupancy !== 4'd0) begin errors++; $display("FAIL clamp_occ got %0d exp 0", bus.occupancy); end
    drive(0, 0, 2, 0);
    set_bundle(32'h70, 32'h74);
    tick();
    drive(0, 0, 0, 0);
    checks++; if (bus.deq_pc !== {32'h74, 32'h70} || bus.occupancy !== 4'd2) begin
      errors++; $display("FAIL clamp_head got pc %0h occ %0d exp 0000007400000070 2", bus.deq_pc, bus.occupancy);
    end
  endtask

  task automatic test_random();
    int f;
    for (int c = 0; c < 400; c++) begin
      f = ($urandom_range(0, 15) == 0) ? 1 : 0;
      drive(f[0], $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3));
      bus.enq_pc   = {$urandom(), $urandom()};
      bus.enq_inst = {$urandom(), $urandom()};
      bus.enq_exc  = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (bus.occupancy !== 4'(q.size()) || bus.enq_ready !== ((DEPTH - q.size()) >= ISSUE_W) ||
          bus.deq_avail !== 2'(imin(q.size(), ISSUE_W)) || bus.overflow_err !== m_ovf) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d got occ %0d rdy %0b av %0d ovf %0b exp occ %0d ovf %0b",
                 c, bus.occupancy, bus.enq_ready, bus.deq_avail, bus.overflow_err, q.size(), m_ovf);
      end
      checks++;
      if (bus.deq_pc !== exp_pc() || bus.deq_inst !== exp_inst() || bus.deq_exc !== exp_exc()) begin
        errors++;
        $display("FAIL rand_data cyc %0d got pc %0h inst %0h exc %0h exp pc %0h inst %0h exc %0h",
                 c, bus.deq_pc, bus.deq_inst, bus.deq_exc, exp_pc(), exp_inst(), exp_exc());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    bus.enq_pc   = '0;
    bus.enq_inst = '0;
    bus.enq_exc  = '0;
    m_ovf = 0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_wrap();
    test_keep_flush();
    test_full_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Parameterised multi-lane instruction buffer between the fetch stages and the decoders of the multi-issue core.
- Accepts a bundle of up to ISSUE_W fetched instructions per cycle, with PC and 2-bit fetch-exception code per instruction.
- Presents up to ISSUE_W oldest instructions in order to the decode lanes.
- Supports full flush, and a delay-slot-preserving flush for MIPS branches.

Parameters:
ISSUE_W, 2, lanes per enqueue/dequeue bundle (1..4)
DEPTH, 8, entries; power of two, >= 2*ISSUE_W
DATA_W, 32, instruction word width
CW, $clog2(ISSUE_W+1), width of lane-count fields (derived)
OW, $clog2(DEPTH+1), width of occupancy (derived)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  discard queue contents this cycle
flush_keep  in  1  qualifies flush: retain oldest surviving entry (delay slot)
enq_cnt  in  CW  valid instructions in bundle, lanes 0..enq_cnt-1
enq_inst  in  ISSUE_W*DATA_W  lane k at [k*DATA_W +: DATA_W]
enq_pc  in  ISSUE_W*32  per-lane PC
enq_exc  in  ISSUE_W*2  per-lane fetch exception code
enq_ready  out  1  queue can take a full bundle
deq_avail  out  CW  instructions presented, min(count, ISSUE_W)
deq_inst  out  ISSUE_W*DATA_W  lane k = entry head+k
deq_pc  out  ISSUE_W*32  per-lane PC
deq_exc  out  ISSUE_W*2  per-lane exception code
deq_cnt  in  CW  instructions consumed this cycle, lanes 0..deq_cnt-1
occupancy  out  OW  current entry count
overflow_err  out  1  sticky enqueue-while-not-ready flag

Behaviour:
- Reset (reset==0 at clk edge): head=tail=count=0; enq_ready=1; deq_avail=0; deq_* and occupancy=0; overflow_err=0. Reset overrides flush, enqueue and dequeue in the same cycle.
- enq_ready = (DEPTH - count) >= ISSUE_W. It is derived from registered count only; there is no combinational path from enq_cnt or deq_cnt.
- Effective enqueue: e = min(enq_cnt, ISSUE_W) when enq_ready=1, otherwise 0.
- Dropped bundle: enq_cnt>0 with enq_ready=0 drops the whole bundle and sets overflow_err. overflow_err clears only on reset.
- Effective dequeue: d = min(deq_cnt, deq_avail). Excess deq_cnt is ignored silently.
- Normal update: entries written at tail..tail+e-1 and head advances by d, both mod DEPTH (wrap-around). count_next = count - d + e.
- Simultaneous enqueue and dequeue are legal, including when count==0, where d=0.
- Latency: an instruction enqueued at edge t is first visible on deq_* after edge t (next cycle). There is no write-to-read bypass.
- Outputs are combinational reads of the storage at head+k. Lanes k >= deq_avail drive all-zero inst/pc/exc.
- Ordering: lane 0 is always the oldest; program order is preserved across wrap.
- Full flush (flush=1, flush_keep=0): count_next=0 and head_next=tail_next=0. Dequeue that cycle is still honoured (d reported consumed). Enqueue that cycle is discarded and is not an overflow.
- Keep flush (flush=1, flush_keep=1): let r = count - d.
  - If r>=1: entry at head+d is retained as the sole entry; head_next=head+d, tail_next=head+d+1, count_next=1.
  - If r==0: same as full flush.
  - Enqueue is discarded in both cases.
- flush_keep with flush=0 has no effect.
- occupancy = count. count never exceeds DEPTH.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles with enq_cnt=2 -> occupancy=0, enq_ready=1, deq_avail=0, deq_* all 0, overflow_err=0 after release.
- Fill, latency and order: enqueue bundles PC {0x00,0x04},{0x08,0x0C},{0x10,0x14},{0x18,0x1C} with deq_cnt=0 -> deq_avail=2 one cycle after the first bundle; occupancy=8; enq_ready=0; lane0 pc=0x00, lane1 pc=0x04.
- Overflow: with queue full, enq_cnt=1 -> occupancy stays 8, overflow_err=1 and stays 1 after draining, until reset.
- Wrap and concurrency: from full, deq_cnt=2 and enq_cnt=0, then 4 cycles of deq_cnt=2 with enq_cnt=2 (PCs 0x20..) -> pcs emerge 0x08,0x0C,…,0x1C,0x20,0x24… in order across index wrap; occupancy=6 throughout.
- Keep flush: queue holds PCs 0x40,0x44,0x48; flush=1, flush_keep=1, deq_cnt=1, enq_cnt=2 -> next cycle occupancy=1, deq_avail=1, lane0 pc=0x44, lane1 all 0.
- Full flush and clamp: occupancy=3, flush=1, flush_keep=0, enq_cnt=2 -> occupancy=0 next cycle, no overflow_err. Then 1 entry with deq_cnt=2 -> occupancy=0, head advanced by 1 only.
